// File: rtl/rr_ex_issue_ctrl_if.sv
// Handshake bundle between the RR stage, writeback, EX redirect logic and
// the RR->EX issue controller. The controller connects through the slave
// modport; the pipeline side that drives it uses the master modport.
interface rr_ex_issue_ctrl_if;
  logic       rr_valid;
  logic [2:0] rr_src1_idx;
  logic       rr_src1_used;
  logic [2:0] rr_src2_idx;
  logic       rr_src2_used;
  logic [2:0] rr_dst_idx;
  logic       rr_dst_wr;
  logic       rr_multi;
  logic       wb_valid;
  logic [2:0] wb_dst_idx;
  logic       ex_redirect;
  logic       rr_stall;
  logic       pr_stall;
  logic       pr_flush;
  logic       pr_valid_in;
  logic [7:0] sb_pending;

  modport master (
    output rr_valid, rr_src1_idx, rr_src1_used, rr_src2_idx, rr_src2_used,
           rr_dst_idx, rr_dst_wr, rr_multi, wb_valid, wb_dst_idx, ex_redirect,
    input  rr_stall, pr_stall, pr_flush, pr_valid_in, sb_pending
  );

  modport slave (
    input  rr_valid, rr_src1_idx, rr_src1_used, rr_src2_idx, rr_src2_used,
           rr_dst_idx, rr_dst_wr, rr_multi, wb_valid, wb_dst_idx, ex_redirect,
    output rr_stall, pr_stall, pr_flush, pr_valid_in, sb_pending
  );
endinterface

// File: rtl/rr_ex_issue_ctrl.sv
// RR->EX issue/hazard controller: decides issue vs bubble vs hold for the
// RR->EX pipeline register, flushes on EX redirect and keeps an 8-entry
// scoreboard of registers with outstanding writes.
// Optional macro RR_EX_WB_BYPASS_EN: a source being written back this cycle
// is treated as ready (no RAW stall on the writeback cycle).
//
// state    | meaning
// ST_RUN   | normal issue, RAW hazards stall RR
// ST_BUSY  | multi-cycle op occupies EX, EX held, RR stalled
// ST_REDIR | bubbles after a redirect, issue suppressed
module rr_ex_issue_ctrl #(
  parameter int EX_LAT        = 3,
  parameter int REDIR_BUBBLES = 1
) (
  input logic               clk,
  input logic               rst_bar,
  rr_ex_issue_ctrl_if.slave bus
);

  typedef enum logic [1:0] {ST_RUN, ST_BUSY, ST_REDIR} state_t;

  // BUSY is entered after the issue edge, so it lasts EX_LAT-1 cycles
  localparam logic [2:0] BUSY_LOAD  = 3'(EX_LAT - 2);
  localparam logic [2:0] REDIR_LOAD = (REDIR_BUBBLES == 0) ? 3'd0 : 3'(REDIR_BUBBLES - 1);

  state_t     r_state, w_state_nxt;
  logic [2:0] r_cnt, w_cnt_nxt;
  logic [7:0] r_pend, w_pend_nxt;
  logic [7:0] w_wb_onehot;
  logic [7:0] w_pend_chk;
  logic       w_hazard;
  logic       w_issue;

  // Writeback one-hot and the pending view used by the hazard check
  always_comb begin
    w_wb_onehot = bus.wb_valid ? (8'd1 << bus.wb_dst_idx) : 8'd0;
`ifdef RR_EX_WB_BYPASS_EN
    w_pend_chk  = r_pend & ~w_wb_onehot;
`else
    w_pend_chk  = r_pend;
`endif
  end

  assign w_hazard = bus.rr_valid &
                    ((bus.rr_src1_used & w_pend_chk[bus.rr_src1_idx]) |
                     (bus.rr_src2_used & w_pend_chk[bus.rr_src2_idx]));
  assign w_issue  = bus.rr_valid & ~w_hazard & (r_state == ST_RUN) & ~bus.ex_redirect;

  assign bus.sb_pending = r_pend;

  // Next-state, countdown and pipeline-register controls
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    bus.rr_stall    = w_hazard;
    bus.pr_stall    = 1'b0;
    bus.pr_flush    = 1'b0;
    bus.pr_valid_in = w_issue;
    case (r_state)
      ST_RUN: begin
        if (w_issue && bus.rr_multi) begin
          w_state_nxt = ST_BUSY;
          w_cnt_nxt   = BUSY_LOAD;
        end
      end
      ST_BUSY: begin
        bus.rr_stall    = 1'b1;
        bus.pr_stall    = 1'b1;
        bus.pr_valid_in = 1'b0;
        if (r_cnt == 3'd0) w_state_nxt = ST_RUN;
        else               w_cnt_nxt   = r_cnt - 3'd1;
      end
      ST_REDIR: begin
        bus.rr_stall    = 1'b1;
        bus.pr_valid_in = 1'b0;
        if (r_cnt == 3'd0) w_state_nxt = ST_RUN;
        else               w_cnt_nxt   = r_cnt - 3'd1;
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = 3'd0;
      end
    endcase
    // Redirect overrides any countdown in progress, including BUSY
    if (bus.ex_redirect) begin
      bus.pr_flush = 1'b1;
      bus.rr_stall = 1'b1;
      if (REDIR_BUBBLES == 0) begin
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = 3'd0;
      end else begin
        w_state_nxt = ST_REDIR;
        w_cnt_nxt   = REDIR_LOAD;
      end
    end
  end

  // Scoreboard update: clear applied first so a same-index set wins
  always_comb begin
    w_pend_nxt = r_pend;
    if (bus.wb_valid) w_pend_nxt[bus.wb_dst_idx] = 1'b0;
    if (w_issue && bus.rr_dst_wr) w_pend_nxt[bus.rr_dst_idx] = 1'b1;
  end

  // State, counter and scoreboard registers
  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) begin
      r_state <= ST_RUN;
      r_cnt   <= 3'd0;
      r_pend  <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

endmodule

// File: tb/tb_rr_ex_issue_ctrl.sv
// Bench for rr_ex_issue_ctrl: directed vector table, hand sequences for
// RAW/reset corners, and a random stream against a cycle-count model.
module tb_rr_ex_issue_ctrl;
  localparam int EX_LAT        = 3;
  localparam int REDIR_BUBBLES = 2;

  logic clk = 1'b0;
  logic rst_bar;
  always #5 clk = ~clk;

  rr_ex_issue_ctrl_if bus();

  rr_ex_issue_ctrl #(.EX_LAT(EX_LAT), .REDIR_BUBBLES(REDIR_BUBBLES)) dut (
    .clk(clk), .rst_bar(rst_bar), .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: pending bits plus remaining busy/bubble cycle counts
  bit [7:0] m_pend;
  int       m_busy_left;
  int       m_bubble_left;
  bit       m_issue, m_rs, m_ps, m_pf, m_pv;

  typedef struct {
    logic v; logic [2:0] s1; logic u1; logic [2:0] s2; logic u2;
    logic [2:0] d; logic w; logic m; logic wbv; logic [2:0] wbd; logic rd;
    logic e_rs; logic e_ps; logic e_pf; logic e_pv; logic [7:0] e_sb;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(input logic v, input logic [2:0] s1, input logic u1,
                              input logic [2:0] s2, input logic u2, input logic [2:0] d,
                              input logic w, input logic m, input logic wbv,
                              input logic [2:0] wbd, input logic rd, input logic ers,
                              input logic eps, input logic epf, input logic epv,
                              input logic [7:0] esb);
    vec_t t;
    t.v = v; t.s1 = s1; t.u1 = u1; t.s2 = s2; t.u2 = u2; t.d = d; t.w = w; t.m = m;
    t.wbv = wbv; t.wbd = wbd; t.rd = rd;
    t.e_rs = ers; t.e_ps = eps; t.e_pf = epf; t.e_pv = epv; t.e_sb = esb;
    return t;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] s1, input logic u1,
                       input logic [2:0] s2, input logic u2, input logic [2:0] d,
                       input logic w, input logic m, input logic wbv,
                       input logic [2:0] wbd, input logic rd);
    bus.rr_valid = v; bus.rr_src1_idx = s1; bus.rr_src1_used = u1;
    bus.rr_src2_idx = s2; bus.rr_src2_used = u2; bus.rr_dst_idx = d;
    bus.rr_dst_wr = w; bus.rr_multi = m; bus.wb_valid = wbv;
    bus.wb_dst_idx = wbd; bus.ex_redirect = rd;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic model_reset();
    m_pend = 8'h00;
    m_busy_left = 0;
    m_bubble_left = 0;
  endtask

  task automatic model_eval();
    bit [7:0] chkp;
    bit haz, run;
    chkp = m_pend;
`ifdef RR_EX_WB_BYPASS_EN
    if (bus.wb_valid) chkp[bus.wb_dst_idx] = 1'b0;
`endif
    haz = bus.rr_valid && ((bus.rr_src1_used && chkp[bus.rr_src1_idx]) ||
                           (bus.rr_src2_used && chkp[bus.rr_src2_idx]));
    run = (m_busy_left == 0) && (m_bubble_left == 0);
    m_issue = bus.rr_valid && !haz && run && !bus.ex_redirect;
    m_rs = bus.ex_redirect || !run || haz;
    m_ps = (m_busy_left > 0);
    m_pf = bus.ex_redirect;
    m_pv = m_issue;
  endtask

  task automatic model_update();
    if (bus.wb_valid) m_pend[bus.wb_dst_idx] = 1'b0;
    if (m_issue && bus.rr_dst_wr) m_pend[bus.rr_dst_idx] = 1'b1;
    if (bus.ex_redirect) begin
      m_busy_left = 0;
      m_bubble_left = REDIR_BUBBLES;
    end else if (m_busy_left > 0) m_busy_left--;
    else if (m_bubble_left > 0) m_bubble_left--;
    else if (m_issue && bus.rr_multi) m_busy_left = EX_LAT - 1;
  endtask

  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic check_model(input string tag);
    chk1({tag, ".rr_stall"}, bus.rr_stall, m_rs);
    chk1({tag, ".pr_stall"}, bus.pr_stall, m_ps);
    chk1({tag, ".pr_flush"}, bus.pr_flush, m_pf);
    chk1({tag, ".pr_valid_in"}, bus.pr_valid_in, m_pv);
    chk8({tag, ".sb_pending"}, bus.sb_pending, m_pend);
  endtask

  task automatic do_reset();
    idle();
    rst_bar = 1'b0;
    #2;
    rst_bar = 1'b1;
    model_reset();
  endtask

  initial begin
    // directed table, starting from reset (EX_LAT=3, REDIR_BUBBLES=2)
    //           v s1 u1 s2 u2 d w m wbv wbd rd | rs ps pf pv sb
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    tbl[1]  = mk(1, 0, 0, 0, 0, 5, 1, 0, 1, 5, 0, 0, 0, 0, 1, 8'h00);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h20);
    tbl[3]  = mk(1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 8'h20);
    tbl[4]  = mk(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 1, 1, 0, 0, 8'h22);
    tbl[5]  = mk(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 1, 1, 0, 0, 8'h22);
    tbl[6]  = mk(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 1, 8'h22);
    tbl[7]  = mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 1, 1, 0, 1, 0, 8'h26);
    tbl[8]  = mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 1, 0, 0, 0, 8'h26);
    tbl[9]  = mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 1, 0, 0, 0, 8'h26);
    tbl[10] = mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 8'h26);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 8'h2E);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 8'h2C);
    tbl[13] = mk(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 8'h2C);
    tbl[14] = mk(1, 7, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h2C);
    tbl[15] = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 8'h2C);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 8'h2C);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 8'h2C);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 8'h2C);
    tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h2C);

    // power-on reset: outputs are defined before any clock edge
    idle();
    bus.rr_valid = 1'b1;
    rst_bar = 1'b0;
    model_reset();
    #3;
    chk1("por.rr_stall", bus.rr_stall, 1'b0);
    chk1("por.pr_stall", bus.pr_stall, 1'b0);
    chk1("por.pr_flush", bus.pr_flush, 1'b0);
    chk1("por.pr_valid_in", bus.pr_valid_in, 1'b1);
    chk8("por.sb_pending", bus.sb_pending, 8'h00);
    idle();
    @(negedge clk);
    rst_bar = 1'b1;
    @(posedge clk);
    #1;

    // directed vector table
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].v, tbl[i].s1, tbl[i].u1, tbl[i].s2, tbl[i].u2, tbl[i].d,
            tbl[i].w, tbl[i].m, tbl[i].wbv, tbl[i].wbd, tbl[i].rd);
      settle();
      chk1($sformatf("vec%0d.rr_stall", i), bus.rr_stall, tbl[i].e_rs);
      chk1($sformatf("vec%0d.pr_stall", i), bus.pr_stall, tbl[i].e_ps);
      chk1($sformatf("vec%0d.pr_flush", i), bus.pr_flush, tbl[i].e_pf);
      chk1($sformatf("vec%0d.pr_valid_in", i), bus.pr_valid_in, tbl[i].e_pv);
      chk8($sformatf("vec%0d.sb_pending", i), bus.sb_pending, tbl[i].e_sb);
      advance();
    end

    // RAW on register 3, resolved by writeback
    do_reset();
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
    settle();
    chk1("raw.producer_issue", bus.pr_valid_in, 1'b1);
    advance();
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      settle();
      chk1("raw.wait_stall", bus.rr_stall, 1'b1);
      chk1("raw.wait_bubble", bus.pr_valid_in, 1'b0);
      advance();
    end
    bus.wb_valid = 1'b1;
    bus.wb_dst_idx = 3'd3;
    settle();
`ifdef RR_EX_WB_BYPASS_EN
    chk1("raw.wb_cycle_issue", bus.pr_valid_in, 1'b1);
    chk1("raw.wb_cycle_stall", bus.rr_stall, 1'b0);
    advance();
`else
    chk1("raw.wb_cycle_issue", bus.pr_valid_in, 1'b0);
    chk1("raw.wb_cycle_stall", bus.rr_stall, 1'b1);
    advance();
    bus.wb_valid = 1'b0;
    settle();
    chk1("raw.after_wb_issue", bus.pr_valid_in, 1'b1);
    chk1("raw.after_wb_stall", bus.rr_stall, 1'b0);
    advance();
`endif
    idle();
    settle();
    chk8("raw.sb_cleared", bus.sb_pending, 8'h00);
    advance();

    // fill scoreboard, start a multi-cycle op, then reset asynchronously
    do_reset();
    for (int r = 0; r < 8; r++) begin
      drive(1, 0, 0, 0, 0, 3'(r), 1, (r == 7), 0, 0, 0);
      settle();
      check_model($sformatf("fill%0d", r));
      advance();
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    chk8("rst.pre_sb", bus.sb_pending, 8'hFF);
    chk1("rst.pre_busy", bus.pr_stall, 1'b1);
    rst_bar = 1'b0;
    #1;
    chk8("rst.sb_pending", bus.sb_pending, 8'h00);
    chk1("rst.pr_stall", bus.pr_stall, 1'b0);
    chk1("rst.rr_stall", bus.rr_stall, 1'b0);
    chk1("rst.pr_flush", bus.pr_flush, 1'b0);
    chk1("rst.pr_valid_in", bus.pr_valid_in, 1'b1);
    model_reset();
    idle();
    @(negedge clk);
    rst_bar = 1'b1;
    @(posedge clk);
    #1;

    // random stream against the model
    for (int n = 0; n < 3000; n++) begin
      logic [2:0] wbd;
      logic wbv;
      int start;
      wbv = ($urandom_range(0, 1) == 1);
      wbd = 3'($urandom_range(0, 7));
      start = $urandom_range(0, 7);
      for (int j = 0; j < 8; j++) begin
        if (m_pend[(start + j) % 8]) wbd = 3'((start + j) % 8);
      end
      drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 1'($urandom),
            3'($urandom_range(0, 7)), 1'($urandom), 3'($urandom_range(0, 7)),
            1'($urandom), ($urandom_range(0, 7) == 0), wbv, wbd,
            ($urandom_range(0, 11) == 0));
      settle();
      check_model("rand");
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
